// File: rtl/sine_tone_meter.sv
// sine_tone_meter: per-period tone measurement (period, max, min, DC offset, amplitude)
// Ports: clk, rst_n (sync, active-low), en, thr, s_valid/s_data in; m_valid, period,
//   vmax, vmin, offset, amp, locked, timeout out. Crossings use thr +/- HYST hysteresis.
module sine_tone_meter #(
  parameter int DW   = 12,
  parameter int CW   = 24,
  parameter int HYST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] thr,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  output logic [CW-1:0] period,
  output logic [DW-1:0] vmax,
  output logic [DW-1:0] vmin,
  output logic [DW-1:0] offset,
  output logic [DW-1:0] amp,
  output logic          locked,
  output logic          timeout
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SYNC,
    LOW_PH,
    HIGH_PH
  } state_t;

  localparam logic signed [DW:0] HB   = (DW+1)'(HYST);
  localparam logic [CW-1:0]      CMAX = {CW{1'b1}};

  state_t st;
  state_t nxt;

  logic [CW-1:0]        cnt;
  logic signed [DW-1:0] tmax;
  logic signed [DW-1:0] tmin;

  logic signed [DW-1:0] sd;
  logic signed [DW:0]   sd_x;
  logic signed [DW:0]   thr_x;
  logic signed [DW:0]   hi;
  logic signed [DW:0]   lo;
  logic                 low_c;
  logic                 high_c;

  logic signed [DW-1:0] nmax;
  logic signed [DW-1:0] nmin;
  logic signed [DW:0]   sum;
  logic signed [DW:0]   dif;

  logic sat;
  logic start_x;
  logic end_x;
  logic tmo;

  // Thresholds one bit wider so thr +/- HYST never wraps.
  assign sd     = s_data;
  assign sd_x   = {sd[DW-1], sd};
  assign thr_x  = {thr[DW-1], thr};
  assign hi     = thr_x + HB;
  assign lo     = thr_x - HB;
  assign low_c  = sd_x < lo;
  assign high_c = sd_x >= hi;

  // Trackers including the current sample, used for tracking and publishing.
  assign nmax = (sd > tmax) ? sd : tmax;
  assign nmin = (sd < tmin) ? sd : tmin;
  assign sum  = {nmax[DW-1], nmax} + {nmin[DW-1], nmin};
  assign dif  = {nmax[DW-1], nmax} - {nmin[DW-1], nmin};

  assign sat = cnt == CMAX;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
    end else begin
      st <= nxt;
    end
  end

  always_comb begin
    nxt     = st;
    start_x = 1'b0;
    end_x   = 1'b0;
    tmo     = 1'b0;
    if (!en) begin
      nxt = IDLE;
    end else begin
      unique case (st)
        IDLE: nxt = ARM;
        ARM: begin
          if (s_valid && low_c) nxt = SYNC;
        end
        SYNC: begin
          if (s_valid && high_c) begin
            nxt     = LOW_PH;
            start_x = 1'b1;
          end
        end
        LOW_PH: begin
          if (s_valid && low_c) nxt = HIGH_PH;
        end
        HIGH_PH: begin
          if (s_valid && high_c) begin
            nxt   = LOW_PH;
            end_x = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
      // A crossing on the saturated sample takes priority over timeout.
      tmo = s_valid && (st != IDLE) && sat
            && !start_x && !end_x;
      if (tmo) nxt = ARM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      tmax    <= '0;
      tmin    <= '0;
      m_valid <= 1'b0;
      timeout <= 1'b0;
      locked  <= 1'b0;
      period  <= '0;
      vmax    <= '0;
      vmin    <= '0;
      offset  <= '0;
      amp     <= '0;
    end else begin
      m_valid <= 1'b0;
      timeout <= tmo;
      if (!en || st == IDLE) begin
        cnt    <= '0;
        locked <= 1'b0;
      end else if (s_valid) begin
        if (tmo) begin
          cnt    <= '0;
          locked <= 1'b0;
        end else if (start_x) begin
          cnt  <= '0;
          tmax <= sd;
          tmin <= sd;
        end else if (end_x) begin
          period  <= sat ? cnt : cnt + CW'(1);
          vmax    <= nmax;
          vmin    <= nmin;
          offset  <= DW'(sum >>> 1);
          amp     <= DW'(dif >> 1);
          m_valid <= 1'b1;
          locked  <= 1'b1;
          cnt     <= '0;
          tmax    <= sd;
          tmin    <= sd;
        end else begin
          cnt <= cnt + CW'(1);
          if (st == LOW_PH || st == HIGH_PH) begin
            tmax <= nmax;
            tmin <= nmin;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_tone_meter.sv
// tb_sine_tone_meter: directed stimulus, queue scoreboard for sine_tone_meter
// Stimulus pushes expected results; a negedge monitor pops on m_valid.
module tb_sine_tone_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [11:0] thr;
  logic        s_valid;
  logic [11:0] s_data;
  logic        m_valid;
  logic [7:0]  period;
  logic [11:0] vmax;
  logic [11:0] vmin;
  logic [11:0] offset;
  logic [11:0] amp;
  logic        locked;
  logic        timeout;

  typedef struct {
    int p;
    int mx;
    int mn;
    int of;
    int am;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  sine_tone_meter #(.DW(12), .CW(8), .HYST(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .thr    (thr),
    .s_valid(s_valid),
    .s_data (s_data),
    .m_valid(m_valid),
    .period (period),
    .vmax   (vmax),
    .vmin   (vmin),
    .offset (offset),
    .amp    (amp),
    .locked (locked),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  task automatic push(input int p, input int mx, input int mn,
                      input int of, input int am);
    res_t r;
    r.p = p; r.mx = mx; r.mn = mn; r.of = of; r.am = am;
    exp_q.push_back(r);
  endtask

  task automatic step(input logic v, input int d);
    s_valid = v;
    s_data  = 12'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic rearm();
    en = 1'b0;
    step(1'b0, 0);
    en = 1'b1;
    step(1'b0, 0);
  endtask

  function automatic int sine(input real a, input real o,
                              input int per, input int n);
    return rnd(o + a * $sin(6.283185307179586 * n / per));
  endfunction

  task automatic tone(input real a, input real o, input int per,
                      input int n0, input int n1, input int stride);
    for (int n = n0; n < n1; n++) begin
      repeat (stride - 1) step(1'b0, 0);
      step(1'b1, sine(a, o, per, n));
    end
  endtask

  task automatic square(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, ((i / 10) % 2 == 0) ? h : l);
    end
  endtask

  task automatic drain(input string nm);
    repeat (3) step(1'b0, 0);
    chk(nm, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    res_t e;
    if (m_valid === 1'b1 || timeout === 1'b1) begin
      chk("mvalid_timeout_excl", int'(m_valid & timeout), 0);
    end
    if (m_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_result got period=%0d want none", period);
      end else begin
        e = exp_q.pop_front();
        chk("period", int'(period), e.p);
        chk("vmax", int'($signed(vmax)), e.mx);
        chk("vmin", int'($signed(vmin)), e.mn);
        chk("offset", int'($signed(offset)), e.of);
        chk("amp", int'(amp), e.am);
        chk("locked_on_result", int'(locked), 1);
      end
    end
  end

  initial begin
    int first;
    int tcnt;
    rst_n   = 1'b0;
    en      = 1'b1;
    thr     = '0;
    s_valid = 1'b0;
    s_data  = '0;

    // reset with live sine and toggling strobe
    for (int k = 0; k < 3; k++) begin
      step(1'(k % 2), sine(1000.0, 0.0, 100, k));
    end
    chk("rst_mvalid", int'(m_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_vmax", int'(vmax), 0);
    chk("rst_vmin", int'(vmin), 0);
    chk("rst_offset", int'(offset), 0);
    chk("rst_amp", int'(amp), 0);
    rst_n = 1'b1;
    en    = 1'b0;
    tone(1000.0, 0.0, 100, 0, 250, 1);
    chk("idle_locked", int'(locked), 0);

    // clean tone: ends at n=201,301,401
    thr = 12'(0);
    rearm();
    repeat (3) push(100, 1000, -1000, 0, 1000);
    tone(1000.0, 0.0, 100, 0, 500, 1);
    chk("clean_locked", int'(locked), 1);
    drain("clean_drained");

    // offset tone: ends at n=129,193,257,321,385
    thr = 12'(200);
    rearm();
    repeat (5) push(64, 700, -300, 200, 500);
    tone(500.0, 200.0, 64, 0, 400, 1);
    drain("offset_drained");

    // hysteresis: +/-10 chatter never crosses, then square period 20
    thr = 12'(0);
    rearm();
    for (int i = 0; i < 10000; i++) begin
      step(1'b1, (i % 2 == 0) ? 10 : -10);
    end
    chk("hyst_locked", int'(locked), 0);
    repeat (8) push(20, 100, -100, 0, 100);
    square(100, -100, 200);
    drain("square_drained");

    // threshold boundaries: 15/-16 miss, 16/-17 hit
    rearm();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, ((i / 5) % 2 == 0) ? 15 : -16);
    end
    chk("edge_no_lock", int'(locked), 0);
    repeat (3) push(20, 16, -17, -1, 16);
    square(16, -17, 100);
    drain("edge_drained");

    // sparse strobes, then en drop mid-period
    rearm();
    repeat (2) push(100, 1000, -1000, 0, 1000);
    tone(1000.0, 0.0, 100, 0, 351, 3);
    en = 1'b0;
    step(1'b1, sine(1000.0, 0.0, 100, 351));
    chk("endrop_locked", int'(locked), 0);
    chk("endrop_mvalid", int'(m_valid), 0);
    chk("hold_period", int'(period), 100);
    chk("hold_vmax", int'($signed(vmax)), 1000);
    chk("hold_amp", int'(amp), 1000);
    tone(1000.0, 0.0, 100, 352, 451, 3);
    drain("sparse_drained");

    // timeout after 255 counted samples
    rearm();
    first = 0;
    for (int k = 1; k <= 300 && first == 0; k++) begin
      step(1'b1, 0);
      if (timeout) first = k;
    end
    chk("timeout_index", first, 256);
    chk("timeout_locked", int'(locked), 0);
    step(1'b1, 0);
    chk("timeout_width", int'(timeout), 0);
    chk("timeout_hold_period", int'(period), 100);

    // crossing on the saturated sample wins
    rearm();
    step(1'b1, -100);
    step(1'b1, 100);
    step(1'b1, -100);
    tcnt = 0;
    repeat (254) begin
      step(1'b1, 0);
      if (timeout) tcnt++;
    end
    chk("sat_pre_timeouts", tcnt, 0);
    push(255, 100, -100, 0, 100);
    step(1'b1, 100);
    chk("sat_mvalid", int'(m_valid), 1);
    chk("sat_timeout", int'(timeout), 0);
    drain("sat_drained");

    // reset mid-period overrides a pending crossing
    rearm();
    push(20, 100, -100, 0, 100);
    square(100, -100, 56);
    chk("pre_rst_locked", int'(locked), 1);
    rst_n = 1'b0;
    step(1'b1, 100);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_mvalid", int'(m_valid), 0);
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_vmax", int'(vmax), 0);
    chk("mid_rst_amp", int'(amp), 0);
    rst_n = 1'b1;
    drain("final_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
